reaction_session_ctrl: RTL and testbench



---
 rtl/reaction_session_ctrl_if.sv | 35 +++
 rtl/reaction_session_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_reaction_session_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/reaction_session_ctrl_if.sv
// reaction_session_ctrl_if
//   Handshake/result bundle for reaction_session_ctrl.
//   master : drives tick_ms (1 kHz strobe), start, enter (debounced pulses);
//            observes LEDs, results and display/done flags.
//   slave  : the controller side of the same signals.
//   TIME_W sets the width of rt_ms, best_ms and avg_ms.
interface reaction_session_ctrl_if #(
  parameter int unsigned TIME_W = 10
);
  logic              tick_ms;
  logic              start;
  logic              enter;
  logic              led_r;
  logic              led_g;
  logic              led_b;
  logic [TIME_W-1:0] rt_ms;
  logic              rt_valid;
  logic [TIME_W-1:0] best_ms;
  logic [TIME_W-1:0] avg_ms;
  logic [3:0]        round_idx;
  logic              done;
  logic              disp_en;

  modport master (
    output tick_ms, start, enter,
    input  led_r, led_g, led_b, rt_ms, rt_valid, best_ms, avg_ms,
           round_idx, done, disp_en
  );

  modport slave (
    input  tick_ms, start, enter,
    output led_r, led_g, led_b, rt_ms, rt_valid, best_ms, avg_ms,
           round_idx, done, disp_en
  );
endinterface

// File: rtl/reaction_session_ctrl.sv
// reaction_session_ctrl
//   Multi-round reaction-time controller. Generates a pseudo-random wait,
//   times each response in ms against tick_ms, applies early/late penalties
//   and reports last, best and average reaction time for a session of
//   ROUNDS trials.
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - reaction_session_ctrl_if.slave: tick_ms/start/enter in;
//          led_r/g/b, rt_ms, rt_valid, best_ms, avg_ms, round_idx, done,
//          disp_en out
// Build option:
//   REACTION_FALSE_START_RETRY_EN - after the EARLY penalty, retry the same
//   trial with a fresh random wait instead of aborting the session.
module reaction_session_ctrl #(
  parameter int unsigned TIME_W       = 10,
  parameter int unsigned ROUNDS       = 4,
  parameter int unsigned RWAIT_MIN_MS = 1000,
  parameter int unsigned RWAIT_SPAN_W = 11,
  parameter int unsigned LATE_MS      = 1000,
  parameter int unsigned PENALTY_MS   = 5000
) (
  input  logic                  clk,
  input  logic                  rst,
  reaction_session_ctrl_if.slave bus
);

  localparam int unsigned SUM_W  = TIME_W + 4;
  localparam int unsigned RLOG   = $clog2(ROUNDS);
  localparam int unsigned WAIT_W = $clog2(RWAIT_MIN_MS + (1 << RWAIT_SPAN_W) + 1);
  localparam int unsigned PEN_W  = $clog2(PENALTY_MS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RWAIT,
    S_REACT,
    S_SHOW,
    S_EARLY,
    S_LATE,
    S_SUMMARY
  } state_t;

  state_t state_q, state_d;

  logic [15:0]       lfsr_q;
  logic [WAIT_W-1:0] wait_q;
  logic [TIME_W-1:0] react_q;
  logic [PEN_W-1:0]  pen_q;
  logic [TIME_W-1:0] rt_q;
  logic              rt_valid_q;
  logic [TIME_W-1:0] best_q;
  logic [TIME_W-1:0] avg_q;
  logic [SUM_W-1:0]  sum_q;
  // One bit wider than round_idx so ROUNDS=16 can be recognised.
  logic [4:0]        round_q;

  logic sess_start, load_wait, take_rt, take_avg, abort;
  logic pen_done;
  logic [WAIT_W-1:0] wait_load;

  assign pen_done  = bus.tick_ms && (pen_q == PEN_W'(PENALTY_MS - 1));
  assign wait_load = WAIT_W'(RWAIT_MIN_MS) + WAIT_W'(lfsr_q[RWAIT_SPAN_W-1:0]);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    sess_start = 1'b0;
    load_wait  = 1'b0;
    take_rt    = 1'b0;
    take_avg   = 1'b0;
    abort      = 1'b0;
    case (state_q)
      S_IDLE, S_SUMMARY: begin
        if (bus.start) begin
          sess_start = 1'b1;
          load_wait  = 1'b1;
          state_d    = S_RWAIT;
        end
      end
      S_RWAIT: begin
        // enter takes priority over a coincident final tick
        if (bus.enter)                                 state_d = S_EARLY;
        else if (bus.tick_ms && wait_q <= WAIT_W'(1))  state_d = S_REACT;
      end
      S_REACT: begin
        if (bus.enter) begin
          take_rt = 1'b1;
          state_d = S_SHOW;
        end else if (bus.tick_ms && react_q == TIME_W'(LATE_MS - 1)) begin
          state_d = S_LATE;
        end
      end
      S_SHOW: begin
        if (bus.start) begin
          if (round_q == 5'(ROUNDS)) begin
            take_avg = 1'b1;
            state_d  = S_SUMMARY;
          end else begin
            load_wait = 1'b1;
            state_d   = S_RWAIT;
          end
        end
      end
      S_EARLY: begin
        if (pen_done) begin
`ifdef REACTION_FALSE_START_RETRY_EN
          load_wait = 1'b1;
          state_d   = S_RWAIT;
`else
          abort   = 1'b1;
          state_d = S_IDLE;
`endif
        end
      end
      S_LATE: begin
        if (pen_done) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q     <= 16'hACE1;
      wait_q     <= '0;
      react_q    <= '0;
      pen_q      <= '0;
      rt_q       <= '0;
      rt_valid_q <= 1'b0;
      best_q     <= '1;
      avg_q      <= '0;
      sum_q      <= '0;
      round_q    <= '0;
    end else begin
      // Galois LFSR, x^16+x^14+x^13+x^11+1
      lfsr_q     <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      rt_valid_q <= take_rt;

      if (load_wait)
        wait_q <= wait_load;
      else if (state_q == S_RWAIT && bus.tick_ms && wait_q != '0)
        wait_q <= wait_q - WAIT_W'(1);

      // Held at zero outside REACT, so it starts from 0 on every entry.
      // A tick that arrives together with enter is not counted.
      if (state_q != S_REACT)
        react_q <= '0;
      else if (bus.tick_ms && !bus.enter && react_q != TIME_W'(LATE_MS))
        react_q <= react_q + TIME_W'(1);

      if (state_q == S_EARLY || state_q == S_LATE) begin
        if (bus.tick_ms) pen_q <= pen_q + PEN_W'(1);
      end else begin
        pen_q <= '0;
      end

      if (sess_start) begin
        round_q <= '0;
        sum_q   <= '0;
        rt_q    <= '0;
        best_q  <= '1;
      end else if (take_rt) begin
        rt_q    <= react_q;
        sum_q   <= sum_q + SUM_W'(react_q);
        round_q <= round_q + 5'd1;
        if (react_q < best_q) best_q <= react_q;
      end else if (abort) begin
        round_q <= '0;
      end

      if (take_avg) avg_q <= TIME_W'(sum_q >> RLOG);
    end
  end

  logic led_r_s, led_g_s, led_b_s, disp_s, done_s;

  always_comb begin
    led_r_s = 1'b0;
    led_g_s = 1'b0;
    led_b_s = 1'b0;
    disp_s  = 1'b0;
    done_s  = 1'b0;
    case (state_q)
      S_REACT:   led_g_s = 1'b1;
      S_SHOW:    begin led_g_s = 1'b1; disp_s = 1'b1; end
      S_EARLY:   led_r_s = 1'b1;
      S_LATE:    begin led_r_s = 1'b1; led_g_s = 1'b1; end
      S_SUMMARY: begin led_b_s = 1'b1; disp_s = 1'b1; done_s = 1'b1; end
      default:   ;
    endcase
  end

  assign bus.led_r     = led_r_s;
  assign bus.led_g     = led_g_s;
  assign bus.led_b     = led_b_s;
  assign bus.disp_en   = disp_s;
  assign bus.done      = done_s;
  assign bus.rt_ms     = rt_q;
  assign bus.rt_valid  = rt_valid_q;
  assign bus.best_ms   = best_q;
  assign bus.avg_ms    = avg_q;
  assign bus.round_idx = round_q[3:0];

endmodule

// File: tb/tb_reaction_session_ctrl.sv
// tb_reaction_session_ctrl
//   Directed bench for reaction_session_ctrl with TIME_W=10, ROUNDS=2,
//   RWAIT_MIN_MS=3, RWAIT_SPAN_W=2, LATE_MS=20, PENALTY_MS=5 and tick_ms
//   every 4 clk. Inputs change on negedge; after each drive() the visible
//   outputs reflect the inputs of the previous drive() call.
module tb_reaction_session_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reaction_session_ctrl_if #(.TIME_W(10)) io ();

  reaction_session_ctrl #(
    .TIME_W(10), .ROUNDS(2), .RWAIT_MIN_MS(3), .RWAIT_SPAN_W(2),
    .LATE_MS(20), .PENALTY_MS(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(io)
  );

  int errors    = 0;
  int checks    = 0;
  int tphase    = 0;
  int rtv_count = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] leds();
    return {io.led_r, io.led_g, io.led_b};
  endfunction

  task automatic drive(input logic s, input logic e);
    @(negedge clk);
    if (io.rt_valid) rtv_count++;
    io.start   = s;
    io.enter   = e;
    io.tick_ms = (tphase == 0);
    tphase     = (tphase + 1) % 4;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    rst    = 1'b0;
    tphase = 0;
  endtask

  // Counts ticks sampled while the LEDs show rgb; next drive must already
  // be sampled in that state. ok=0 if the state never changes.
  task automatic count_while(input logic [2:0] rgb, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (k > 0 && leds() != rgb) begin
        ok = 1'b1;
        break;
      end
      if (tphase == 0) n++;
      drive(1'b0, 1'b0);
    end
  endtask

  task automatic run_rwait(output int n, output bit ok);
    drive(1'b1, 1'b0);
    count_while(3'b000, n, ok);
  endtask

  task automatic react_enter(input int k);
    int c;
    c = 0;
    while (c < k) begin
      if (tphase == 0) c++;
      drive(1'b0, 1'b0);
    end
    drive(1'b0, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, n0, c, rtv0, distinct;
    bit  ok, t, e;
    bit  seen [8];

    io.tick_ms = 1'b0;
    io.start   = 1'b0;
    io.enter   = 1'b0;

    // Reset values
    do_reset();
    check_eq("rst_leds",  leds(), 3'b000);
    check_eq("rst_rt",    io.rt_ms, 0);
    check_eq("rst_best",  io.best_ms, 1023);
    check_eq("rst_avg",   io.avg_ms, 0);
    check_eq("rst_round", io.round_idx, 0);
    check_eq("rst_flags", {io.done, io.disp_en, io.rt_valid}, 3'b000);
    for (int k = 0; k < 12; k++) drive(1'b0, 1'b1);
    check_eq("idle_hold", leds(), 3'b000);

    // Two trials: 7 and 12 ticks
    run_rwait(n, ok);
    check_eq("t1_react_ok", ok, 1);
    check_eq("t1_green",    leds(), 3'b010);
    react_enter(7);
    drive(1'b0, 1'b0);
    check_eq("t1_rt_valid", io.rt_valid, 1);
    check_eq("t1_rt",       io.rt_ms, 7);
    check_eq("t1_best",     io.best_ms, 7);
    check_eq("t1_round",    io.round_idx, 1);
    check_eq("t1_show",     {leds(), io.disp_en}, 4'b0101);
    drive(1'b0, 1'b0);
    check_eq("t1_pulse_end", io.rt_valid, 0);
    run_rwait(n, ok);
    check_eq("t2_react_ok", ok, 1);
    react_enter(12);
    drive(1'b0, 1'b0);
    check_eq("t2_rt_valid", io.rt_valid, 1);
    check_eq("t2_rt",       io.rt_ms, 12);
    check_eq("t2_best",     io.best_ms, 7);
    check_eq("t2_round",    io.round_idx, 2);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    check_eq("sum_avg",     io.avg_ms, 9);
    check_eq("sum_done",    io.done, 1);
    check_eq("sum_leds",    {leds(), io.disp_en}, 4'b0011);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    check_eq("sum_enter_ignored", leds(), 3'b001);

    // New session from SUMMARY, then reset mid-REACT
    run_rwait(n, ok);
    check_eq("s2_react_ok", ok, 1);
    check_eq("s2_round_clr", io.round_idx, 0);
    check_eq("s2_best_clr",  io.best_ms, 1023);
    check_eq("s2_rt_clr",    io.rt_ms, 0);
    check_eq("s2_done_clr",  io.done, 0);
    react_enter(5);
    drive(1'b0, 1'b0);
    check_eq("s2_rt", io.rt_ms, 5);
    run_rwait(n, ok);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    check_eq("pre_rst_green", leds(), 3'b010);
    check_eq("pre_rst_best",  io.best_ms, 5);
    rst = 1'b1;
    drive(1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b0, 1'b0);
    check_eq("mid_rst_leds",  leds(), 3'b000);
    check_eq("mid_rst_rt",    io.rt_ms, 0);
    check_eq("mid_rst_best",  io.best_ms, 1023);
    check_eq("mid_rst_round", io.round_idx, 0);

    // Early press during RWAIT of the second trial
    do_reset();
    run_rwait(n, ok);
    react_enter(4);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    check_eq("early_red", leds(), 3'b100);
    count_while(3'b100, n, ok);
    check_eq("early_ticks", n, 5);
`ifdef REACTION_FALSE_START_RETRY_EN
    check_eq("retry_round", io.round_idx, 1);
    count_while(3'b000, n, ok);
    check_eq("retry_react", {ok, leds()}, {1'b1, 3'b010});
`else
    check_eq("abort_round", io.round_idx, 0);
    for (int k = 0; k < 40; k++) drive(1'b0, 1'b0);
    check_eq("abort_idle", leds(), 3'b000);
`endif

    // No enter in REACT: LATE after 20 ticks, 5-tick penalty
    do_reset();
    rtv0 = rtv_count;
    run_rwait(n, ok);
    count_while(3'b010, n, ok);
    check_eq("late_ticks", n, 20);
    check_eq("late_leds",  leds(), 3'b110);
    count_while(3'b110, n, ok);
    check_eq("late_pen_ticks", n, 5);
    check_eq("late_idle",  leds(), 3'b000);
    check_eq("late_no_rtv", rtv_count - rtv0, 0);

    // enter coincident with the 20th REACT tick
    do_reset();
    run_rwait(n, ok);
    c = 0;
    for (int k = 0; k < 400; k++) begin
      e = (tphase == 0) && (c == 19);
      if (tphase == 0 && !e) c++;
      drive(1'b0, e);
      if (e) break;
    end
    drive(1'b0, 1'b0);
    check_eq("edge_late_show", {leds(), io.disp_en}, 4'b0101);
    check_eq("edge_late_rt",   io.rt_ms, 19);

    // enter coincident with the final RWAIT tick (replay same wait)
    do_reset();
    run_rwait(n0, ok);
    do_reset();
    drive(1'b1, 1'b0);
    c = 0;
    for (int k = 0; k < 400; k++) begin
      t = (tphase == 0);
      e = t && (c + 1 == n0);
      if (t) c++;
      drive(1'b0, e);
      if (e) break;
    end
    drive(1'b0, 1'b0);
    check_eq("edge_rwait_early", leds(), 3'b100);

    // Random wait spread over 32 sessions
    do_reset();
    for (int i = 0; i < 8; i++) seen[i] = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i > 0) begin
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        if (io.round_idx == 4'd2) begin
          drive(1'b1, 1'b0);
          drive(1'b0, 1'b0);
        end
      end
      run_rwait(n, ok);
      check_eq("rwait_in_range", {31'd0, ok && n >= 3 && n <= 6}, 1);
      if (n >= 0 && n < 8) seen[n] = 1'b1;
    end
    distinct = 0;
    for (int i = 0; i < 8; i++) if (seen[i]) distinct++;
    check_eq("rwait_distinct_ge3", {31'd0, distinct >= 3}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
